// File: rtl/decode_aligner.sv
// rtl/decode_aligner.sv - byte-aligned decode window over the fetch circular buffer
//
// Purpose: present a registered WIN_BYTES-byte window starting at the decode
// point of the fetch stage's circular buffer, together with the RIP of that
// point and the number of valid bytes. Advances on accepted consumes and
// returns the decode offset to fetch for flow control.
//
// Ports:
//   clk, reset        core clock, asynchronous active-high reset
//   entry             program entry RIP, loaded in the first cycle after reset
//   fetch_offset_in   fetch write offset (one past last valid byte)
//   decode_buffer_in  circular buffer, byte k at bits [8k : 8k+7]
//   decode_offset_in  decode read offset, returned to fetch
//   win_valid         window holds at least one valid byte
//   win_bytes         window, byte j at bits [8j : 8j+7]
//   win_avail         min(bytes available, WIN_BYTES)
//   win_rip           RIP of window byte 0
//   consume_valid     downstream retires consume_len bytes this cycle
//   consume_len       instruction length, 1..15
//   consume_err       one-cycle pulse on a rejected consume
//   insn_count        accepted consumes since reset

module decode_aligner #(
  parameter int BUF_BYTES = 128,
  parameter int WIN_BYTES = 15,
  parameter int OFF_W     = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [63:0]              entry,
  input  logic [OFF_W-1:0]         fetch_offset_in,
  input  logic [0:BUF_BYTES*8-1]   decode_buffer_in,
  output logic [OFF_W-1:0]         decode_offset_in,
  output logic                     win_valid,
  output logic [0:WIN_BYTES*8-1]   win_bytes,
  output logic [3:0]               win_avail,
  output logic [63:0]              win_rip,
  input  logic                     consume_valid,
  input  logic [3:0]               consume_len,
  output logic                     consume_err,
  output logic [63:0]              insn_count
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic                   acc;
  logic [OFF_W-1:0]       next_off;
  logic [OFF_W-1:0]       avail;
  logic [3:0]             avail_clip;
  logic [0:WIN_BYTES*8-1] next_win;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: S_INIT lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  // A consume is only legal against bytes the current window actually holds
  assign acc = consume_valid & win_valid & (consume_len != 4'd0) &
               (consume_len <= win_avail);

  // Offset arithmetic wraps naturally at OFF_W bits (buffer is a power of two)
  assign next_off   = decode_offset_in + (acc ? OFF_W'(consume_len) : '0);
  assign avail      = fetch_offset_in - next_off;
  assign avail_clip = (avail > OFF_W'(WIN_BYTES)) ? 4'(WIN_BYTES) : avail[3:0];

  // Rotate the buffer so the byte at next_off lands in window byte 0;
  // indices wrap so windows crossing the buffer end stay contiguous.
  always_comb begin
    next_win = '0;
    for (int j = 0; j < WIN_BYTES; j++) begin
      next_win[j*8 +: 8] =
        decode_buffer_in[8*int'(OFF_W'(next_off + OFF_W'(j))) +: 8];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decode_offset_in <= '0;
      win_valid        <= 1'b0;
      win_bytes        <= '0;
      win_avail        <= '0;
      win_rip          <= '0;
      consume_err      <= 1'b0;
      insn_count       <= '0;
    end else if (state == S_INIT) begin
      // Consumes here are ignored without flagging an error
      win_rip     <= entry;
      consume_err <= 1'b0;
    end else begin
      // Window reloads every cycle so newly fetched bytes show up without a consume
      decode_offset_in <= next_off;
      win_bytes        <= next_win;
      win_avail        <= avail_clip;
      win_valid        <= (avail != '0);
      consume_err      <= consume_valid & ~acc;
      if (acc) begin
        win_rip    <= win_rip + 64'(consume_len);
        insn_count <= insn_count + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_aligner.sv
// tb/tb_decode_aligner.sv - self-checking bench for decode_aligner

module tb_decode_aligner;

  localparam int BUF = 128;
  localparam int WIN = 15;
  localparam int OW  = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [63:0]       entry;
  logic [OW-1:0]     fetch_offset_in;
  logic [0:BUF*8-1]  decode_buffer_in;
  logic [OW-1:0]     decode_offset_in;
  logic              win_valid;
  logic [0:WIN*8-1]  win_bytes;
  logic [3:0]        win_avail;
  logic [63:0]       win_rip;
  logic              consume_valid;
  logic [3:0]        consume_len;
  logic              consume_err;
  logic [63:0]       insn_count;

  int n_vec = 0;
  int n_err = 0;

  decode_aligner #(.BUF_BYTES(BUF), .WIN_BYTES(WIN), .OFF_W(OW)) dut (
    .clk              (clk),
    .reset            (reset),
    .entry            (entry),
    .fetch_offset_in  (fetch_offset_in),
    .decode_buffer_in (decode_buffer_in),
    .decode_offset_in (decode_offset_in),
    .win_valid        (win_valid),
    .win_bytes        (win_bytes),
    .win_avail        (win_avail),
    .win_rip          (win_rip),
    .consume_valid    (consume_valid),
    .consume_len      (consume_len),
    .consume_err      (consume_err),
    .insn_count       (insn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: integer offsets mod BUF, byte array window
  bit          m_run = 0;
  int          m_off = 0;
  int          m_avail = 0;
  bit          m_valid = 0;
  bit          m_err = 0;
  logic [63:0] m_rip = '0;
  logic [63:0] m_cnt = '0;
  logic [7:0]  m_win [WIN];

  int          n_len;
  bit          n_acc;
  int          n_off;
  int          n_av;
  logic [7:0]  n_win [WIN];

  always_comb begin
    n_len = int'(consume_len);
    n_acc = consume_valid && m_valid && (n_len > 0) && (n_len <= m_avail);
    n_off = n_acc ? (m_off + n_len) % BUF : m_off;
    n_av  = (int'(fetch_offset_in) - n_off + BUF) % BUF;
    for (int j = 0; j < WIN; j++) begin
      n_win[j] = decode_buffer_in[((n_off + j) % BUF) * 8 +: 8];
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run   <= 0;
      m_off   <= 0;
      m_avail <= 0;
      m_valid <= 0;
      m_err   <= 0;
      m_rip   <= '0;
      m_cnt   <= '0;
      for (int j = 0; j < WIN; j++) m_win[j] <= '0;
    end else if (!m_run) begin
      m_run <= 1;
      m_rip <= entry;
      m_err <= 0;
    end else begin
      m_off   <= n_off;
      m_avail <= (n_av < WIN) ? n_av : WIN;
      m_valid <= (n_av != 0);
      m_err   <= consume_valid && !n_acc;
      if (n_acc) begin
        m_rip <= m_rip + 64'(n_len);
        m_cnt <= m_cnt + 64'd1;
      end
      for (int j = 0; j < WIN; j++) m_win[j] <= n_win[j];
    end
  end

  // Every-cycle compare against the model; bytes past win_avail are don't-care
  logic [0:WIN*8-1] exp_w, act_w;
  initial begin
    for (int j = 0; j < WIN; j++) m_win[j] = '0;
    forever begin
      @(negedge clk);
      chk("m_offset", decode_offset_in, m_off);
      chk("m_valid",  win_valid, m_valid);
      chk("m_avail",  win_avail, m_avail);
      chk("m_rip",    win_rip, m_rip);
      chk("m_err",    consume_err, m_err);
      chk("m_count",  insn_count, m_cnt);
      exp_w = '0;
      act_w = '0;
      for (int j = 0; j < WIN; j++) begin
        if (j < m_avail) begin
          exp_w[j*8 +: 8] = m_win[j];
          act_w[j*8 +: 8] = win_bytes[j*8 +: 8];
        end
      end
      chk("m_win_bytes", act_w, exp_w);
    end
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    entry           = '0;
    fetch_offset_in = '0;
    consume_valid   = 1'b0;
    consume_len     = '0;
    for (int k = 0; k < BUF; k++) decode_buffer_in[k*8 +: 8] = 8'(k + 16);

    repeat (3) @(negedge clk);
    chk("rst_offset", decode_offset_in, 0);
    chk("rst_valid",  win_valid, 0);
    chk("rst_rip",    win_rip, 0);
    chk("rst_count",  insn_count, 0);

    reset = 1'b0;
    entry = 64'h4000_1003;
    @(negedge clk);
    chk("init_rip", win_rip, 64'h4000_1003);
    @(negedge clk);
    chk("empty_valid", win_valid, 0);

    fetch_offset_in = 7'd8;
    @(negedge clk);
    chk("fill_valid", win_valid, 1);
    chk("fill_avail", win_avail, 8);
    chk("fill_bytes", win_bytes[0:63], 64'h1011_1213_1415_1617);

    consume_valid = 1'b1;
    consume_len   = 4'd3;
    @(negedge clk);
    chk("c3_offset", decode_offset_in, 3);
    chk("c3_rip",    win_rip, 64'h4000_1006);
    chk("c3_avail",  win_avail, 5);
    chk("c3_byte0",  win_bytes[0:7], 8'h13);
    chk("c3_count",  insn_count, 1);

    consume_len = 4'd5;
    @(negedge clk);
    chk("c5_valid", win_valid, 0);
    chk("c5_count", insn_count, 2);

    // Walk the decode point to 124 with fetch a near-full buffer ahead
    consume_valid   = 1'b0;
    fetch_offset_in = 7'd0;
    @(negedge clk);
    consume_valid = 1'b1;
    consume_len   = 4'd15;
    repeat (7) @(negedge clk);
    consume_len = 4'd11;
    @(negedge clk);
    consume_valid   = 1'b0;
    fetch_offset_in = 7'd12;
    @(negedge clk);
    chk("wrap_offset", decode_offset_in, 124);
    chk("wrap_avail",  win_avail, 15);
    chk("wrap_bytes",  win_bytes[0:119], 120'h8C8D8E8F_10111213_14151617_18191A);

    consume_valid = 1'b1;
    consume_len   = 4'd6;
    @(negedge clk);
    chk("wrap_c6_offset", decode_offset_in, 2);
    @(negedge clk);
    chk("c6b_avail", win_avail, 4);

    consume_len = 4'd9;
    @(negedge clk);
    chk("long_err",    consume_err, 1);
    chk("long_offset", decode_offset_in, 8);
    chk("long_count",  insn_count, 12);
    consume_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse", consume_err, 0);

    consume_valid = 1'b1;
    consume_len   = 4'd0;
    @(negedge clk);
    chk("zero_err", consume_err, 1);
    consume_len = 4'd4;
    @(negedge clk);
    chk("drain_valid", win_valid, 0);
    chk("drain_err",   consume_err, 0);
    consume_len = 4'd1;
    @(negedge clk);
    chk("empty_err",   consume_err, 1);
    chk("empty_count", insn_count, 13);

    // Advance to offset 50, then reset asynchronously mid-consume
    consume_valid   = 1'b0;
    fetch_offset_in = 7'd60;
    @(negedge clk);
    consume_valid = 1'b1;
    consume_len   = 4'd15;
    repeat (2) @(negedge clk);
    consume_len = 4'd8;
    @(negedge clk);
    chk("pre_rst_offset", decode_offset_in, 50);
    consume_len = 4'd3;
    #2 reset = 1'b1;
    #1;
    chk("arst_offset", decode_offset_in, 0);
    chk("arst_valid",  win_valid, 0);
    chk("arst_avail",  win_avail, 0);
    chk("arst_rip",    win_rip, 0);
    chk("arst_count",  insn_count, 0);

    @(negedge clk);
    reset         = 1'b0;
    entry         = 64'h0000_0000_0000_1234;
    consume_valid = 1'b1;
    consume_len   = 4'd2;
    @(negedge clk);
    chk("reinit_rip",    win_rip, 64'h1234);
    chk("reinit_err",    consume_err, 0);
    chk("reinit_count",  insn_count, 0);
    chk("reinit_offset", decode_offset_in, 0);
    consume_valid = 1'b0;
    @(negedge clk);
    chk("reload_valid", win_valid, 1);
    chk("reload_avail", win_avail, 15);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
